// File: rtl/apb_mux_pkg.sv
// Shared types and helpers for the APB decode mux.
// Build option: APB_MUX_TIMEOUT_EN enables the ACCESS wait-state timeout.
package apb_mux_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, DECERR} apb_mux_state_e;

  localparam int MAX_SLV   = 16;
  localparam int MAX_IDX_W = $clog2(MAX_SLV);

  function automatic int idx_width(input int num_slv);
    return $clog2(num_slv);
  endfunction

  function automatic int wcnt_width(input int timeout_cyc);
    return $clog2(timeout_cyc + 1);
  endfunction

  // Indices at or above n produce an all-zero vector.
  function automatic logic [MAX_SLV-1:0] onehot(input logic [MAX_IDX_W-1:0] idx, input int n);
    logic [MAX_SLV-1:0] oh;
    oh = '0;
    for (int i = 0; i < MAX_SLV; i++) begin
      oh[i] = (i < n) && (idx == MAX_IDX_W'(i));
    end
    return oh;
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational APB address decode: slave index field plus decode-error flag.
// Build option: none (APB_MUX_TIMEOUT_EN only affects apb_decode_mux).
module apb_addr_decoder #(
  parameter int NUM_SLV = 4,
  parameter int ADDR_W  = 32,
  parameter int IDX_LSB = 12,
  parameter int IDX_W   = $clog2(NUM_SLV)
) (
  input  logic [ADDR_W-1:0] paddr_i,
  output logic [IDX_W-1:0]  idx_o,
  output logic              dec_err_o
);

  logic [ADDR_W-1:0] upper;
  logic              idx_err;

  assign idx_o = paddr_i[IDX_LSB +: IDX_W];
  assign upper = paddr_i >> (IDX_LSB + IDX_W);

  // With a power-of-two slave count every index value is a real slave.
  if (NUM_SLV < (1 << IDX_W)) begin : g_idx_range
    assign idx_err = (32'(idx_o) >= 32'(NUM_SLV));
  end else begin : g_idx_full
    assign idx_err = 1'b0;
  end

  assign dec_err_o = idx_err || (|upper);

endmodule

// File: rtl/apb_decode_mux.sv
// APB one-master/NUM_SLV-slave decode and return mux with decode-error response.
// Build option: APB_MUX_TIMEOUT_EN adds an ACCESS wait-state timeout (TIMEOUT_CYC).
//
// state  | meaning
// IDLE   | no transfer, or SETUP cycle when psel=1
// ACCESS | valid slave selected (sel_q), waiting for its pready
// DECERR | one-cycle error response for an unmapped address
module apb_decode_mux
  import apb_mux_pkg::*;
#(
  parameter int NUM_SLV     = 4,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int IDX_LSB     = 12,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic               pclk,
  input  logic               presetn,
  input  logic               psel,
  input  logic               penable,
  input  logic [ADDR_W-1:0]  paddr,
  output logic [NUM_SLV-1:0] slv_psel,
  output logic               slv_penable,
  input  logic [DATA_W-1:0]  prdata  [NUM_SLV],
  input  logic               pready  [NUM_SLV],
  input  logic               pslverr [NUM_SLV],
  output logic [DATA_W-1:0]  mst_prdata,
  output logic               mst_pready,
  output logic               mst_pslverr
);

  localparam int IDX_W = idx_width(NUM_SLV);

  if (NUM_SLV < 2 || NUM_SLV > MAX_SLV) begin : g_bad_num_slv
    $error("apb_decode_mux: NUM_SLV must be 2..16");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("apb_decode_mux: TIMEOUT_CYC must be >= 1");
  end

  apb_mux_state_e     state_q, state_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [IDX_W-1:0]   dec_idx;
  logic               dec_err;
  logic               sel_rdy;
  logic               timeout;

  logic [NUM_SLV-1:0] psel_c;
  logic               penable_c;
  logic [DATA_W-1:0]  prdata_c;
  logic               pready_c;
  logic               pslverr_c;

  apb_addr_decoder #(
    .NUM_SLV (NUM_SLV),
    .ADDR_W  (ADDR_W),
    .IDX_LSB (IDX_LSB),
    .IDX_W   (IDX_W)
  ) u_dec (
    .paddr_i   (paddr),
    .idx_o     (dec_idx),
    .dec_err_o (dec_err)
  );

  assign sel_rdy = pready[sel_q];

`ifdef APB_MUX_TIMEOUT_EN
  localparam int WCNT_W = wcnt_width(TIMEOUT_CYC);
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;

  // A late pready on the terminal cycle still wins over the timeout.
  assign timeout = (state_q == ACCESS) && (wcnt_q == WCNT_W'(TIMEOUT_CYC)) && !sel_rdy;

  always_comb begin
    wcnt_d = wcnt_q;
    if (state_q != ACCESS) begin
      wcnt_d = '0;
    end else if (!sel_rdy && !timeout) begin
      wcnt_d = wcnt_q + WCNT_W'(1);
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) wcnt_q <= '0;
    else          wcnt_q <= wcnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    psel_c    = '0;
    penable_c = 1'b0;
    prdata_c  = '0;
    pready_c  = 1'b0;
    pslverr_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (psel) begin
          if (dec_err) begin
            state_d = DECERR;
          end else begin
            psel_c  = NUM_SLV'(onehot(MAX_IDX_W'(dec_idx), NUM_SLV));
            sel_d   = dec_idx;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (timeout) begin
          pready_c  = 1'b1;
          pslverr_c = 1'b1;
          state_d   = IDLE;
        end else begin
          psel_c    = NUM_SLV'(onehot(MAX_IDX_W'(sel_q), NUM_SLV));
          penable_c = penable;
          prdata_c  = prdata[sel_q];
          pready_c  = sel_rdy;
          pslverr_c = pslverr[sel_q];
          if (sel_rdy) state_d = IDLE;
        end
      end
      DECERR: begin
        pready_c  = 1'b1;
        pslverr_c = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are combinational, so gate them to keep everything quiet while in reset.
  assign slv_psel    = presetn ? psel_c    : '0;
  assign slv_penable = presetn && penable_c;
  assign mst_prdata  = presetn ? prdata_c  : '0;
  assign mst_pready  = presetn && pready_c;
  assign mst_pslverr = presetn && pslverr_c;

endmodule

// File: tb/tb_apb_decode_mux.sv
// Directed self-checking bench for apb_decode_mux (NUM_SLV=4, IDX_LSB=12).
// Build option: APB_MUX_TIMEOUT_EN selects the timeout scenario instead of the unbounded wait.
module tb_apb_decode_mux;

  localparam int NUM_SLV = 4;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;

  logic               pclk;
  logic               presetn;
  logic               psel;
  logic               penable;
  logic [ADDR_W-1:0]  paddr;
  logic [NUM_SLV-1:0] slv_psel;
  logic               slv_penable;
  logic [DATA_W-1:0]  prdata  [NUM_SLV];
  logic               pready  [NUM_SLV];
  logic               pslverr [NUM_SLV];
  logic [DATA_W-1:0]  mst_prdata;
  logic               mst_pready;
  logic               mst_pslverr;

  int n_tests;
  int n_fail;

  apb_decode_mux #(
    .NUM_SLV     (NUM_SLV),
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .IDX_LSB     (12),
    .TIMEOUT_CYC (16)
  ) dut (
    .pclk        (pclk),
    .presetn     (presetn),
    .psel        (psel),
    .penable     (penable),
    .paddr       (paddr),
    .slv_psel    (slv_psel),
    .slv_penable (slv_penable),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr),
    .mst_prdata  (mst_prdata),
    .mst_pready  (mst_pready),
    .mst_pslverr (mst_pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change 1 ns after the rising edge; checks happen at the falling edge.
  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic mid();
    @(negedge pclk);
  endtask

  task automatic idle_bus();
    psel = 1'b0; penable = 1'b0; paddr = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      prdata[i] = 32'hA000_0000 + 32'(i); pready[i] = 1'b0; pslverr[i] = 1'b0;
    end
  endtask

  task automatic test_reset();
    presetn = 1'b0;
    idle_bus();
    psel = 1'b1; paddr = 32'h2004; pready[2] = 1'b1;
    #3;
    n_tests++;
    if ({slv_psel, slv_penable, mst_pready, mst_pslverr, mst_prdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: psel=%b pen=%b rdy=%b err=%b data=%h required all zero",
               slv_psel, slv_penable, mst_pready, mst_pslverr, mst_prdata);
    end
    psel = 1'b0;
    step();
    presetn = 1'b1;
    step();
    mid();
    n_tests++;
    if ({slv_psel, mst_pready} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_idle: psel=%b rdy=%b required 0000/0", slv_psel, mst_pready);
    end
  endtask

  task automatic test_read();
    step();
    idle_bus();
    psel = 1'b1; paddr = 32'h2004; pready[2] = 1'b1; prdata[2] = 32'hDEAD_BEEF;
    mid();
    n_tests++;
    if ({slv_psel, slv_penable, mst_pready} !== {4'b0100, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL read_setup: psel=%b pen=%b rdy=%b required 0100/0/0", slv_psel, slv_penable, mst_pready);
    end
    step();
    penable = 1'b1;
    mid();
    n_tests++;
    if ({slv_psel, slv_penable, mst_pready, mst_pslverr, mst_prdata} !==
        {4'b0100, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL read_access: psel=%b pen=%b rdy=%b err=%b data=%h required 0100/1/1/0/deadbeef",
               slv_psel, slv_penable, mst_pready, mst_pslverr, mst_prdata);
    end
    step();
    idle_bus();
    mid();
    n_tests++;
    if ({slv_psel, mst_pready, mst_prdata} !== '0) begin
      n_fail++;
      $display("FAIL read_done: psel=%b rdy=%b data=%h required idle zeros", slv_psel, mst_pready, mst_prdata);
    end
  endtask

  task automatic test_decerr();
    logic [ADDR_W-1:0] bad_addr [2];
    bad_addr[0] = 32'h0001_0000;
    bad_addr[1] = 32'h8000_3000;
    for (int k = 0; k < 2; k++) begin
      step();
      idle_bus();
      for (int i = 0; i < NUM_SLV; i++) pready[i] = 1'b1;
      psel = 1'b1; paddr = bad_addr[k];
      mid();
      n_tests++;
      if ({slv_psel, mst_pready, mst_pslverr} !== 6'b0) begin
        n_fail++;
        $display("FAIL decerr_setup[%0d]: psel=%b rdy=%b err=%b required 0000/0/0", k, slv_psel, mst_pready, mst_pslverr);
      end
      step();
      penable = 1'b1;
      mid();
      n_tests++;
      if ({slv_psel, slv_penable, mst_pready, mst_pslverr, mst_prdata} !==
          {4'b0000, 1'b0, 1'b1, 1'b1, 32'h0}) begin
        n_fail++;
        $display("FAIL decerr_access[%0d]: psel=%b pen=%b rdy=%b err=%b data=%h required 0000/0/1/1/0",
                 k, slv_psel, slv_penable, mst_pready, mst_pslverr, mst_prdata);
      end
    end
    step();
    idle_bus();
  endtask

  task automatic test_wait_states();
    step();
    idle_bus();
    psel = 1'b1; paddr = 32'h1000; prdata[1] = 32'h1111_2222;
    mid();
    n_tests++;
    if (slv_psel !== 4'b0010) begin
      n_fail++;
      $display("FAIL wait_setup: psel=%b required 0010", slv_psel);
    end
    for (int c = 1; c <= 3; c++) begin
      step();
      penable = 1'b1;
      paddr = 32'h3000 + 32'(c);
      pready[3] = 1'b1;
      mid();
      n_tests++;
      if ({slv_psel, slv_penable, mst_pready} !== {4'b0010, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL wait_cycle%0d: psel=%b pen=%b rdy=%b required 0010/1/0", c, slv_psel, slv_penable, mst_pready);
      end
    end
    step();
    pready[1] = 1'b1;
    mid();
    n_tests++;
    if ({slv_psel, mst_pready, mst_pslverr, mst_prdata} !== {4'b0010, 1'b1, 1'b0, 32'h1111_2222}) begin
      n_fail++;
      $display("FAIL wait_done: psel=%b rdy=%b err=%b data=%h required 0010/1/0/11112222",
               slv_psel, mst_pready, mst_pslverr, mst_prdata);
    end
    step();
    idle_bus();
  endtask

  task automatic test_back_to_back();
    step();
    idle_bus();
    psel = 1'b1; paddr = 32'h0000_0010; pready[0] = 1'b1; prdata[0] = 32'h0BAD_F00D;
    step();
    penable = 1'b1;
    mid();
    n_tests++;
    if ({slv_psel, mst_pready, mst_pslverr, mst_prdata} !== {4'b0001, 1'b1, 1'b0, 32'h0BAD_F00D}) begin
      n_fail++;
      $display("FAIL b2b_first: psel=%b rdy=%b err=%b data=%h required 0001/1/0/0badf00d",
               slv_psel, mst_pready, mst_pslverr, mst_prdata);
    end
    step();
    penable = 1'b0; paddr = 32'h3000; pready[0] = 1'b0;
    pready[3] = 1'b1; prdata[3] = 32'hCAFE_0003; pslverr[3] = 1'b1;
    mid();
    n_tests++;
    if ({slv_psel, slv_penable, mst_pready} !== {4'b1000, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_setup2: psel=%b pen=%b rdy=%b required 1000/0/0", slv_psel, slv_penable, mst_pready);
    end
    step();
    penable = 1'b1;
    mid();
    n_tests++;
    if ({slv_psel, mst_pready, mst_pslverr, mst_prdata} !== {4'b1000, 1'b1, 1'b1, 32'hCAFE_0003}) begin
      n_fail++;
      $display("FAIL b2b_second: psel=%b rdy=%b err=%b data=%h required 1000/1/1/cafe0003",
               slv_psel, mst_pready, mst_pslverr, mst_prdata);
    end
    step();
    idle_bus();
  endtask

  task automatic test_abort();
    step();
    idle_bus();
    psel = 1'b1; paddr = 32'h1000;
    step();
    penable = 1'b1;
    step();
    psel = 1'b0; penable = 1'b0; pready[1] = 1'b1;
    mid();
    n_tests++;
    if ({slv_psel, slv_penable, mst_pready, mst_pslverr} !== 7'b0) begin
      n_fail++;
      $display("FAIL abort_drop: psel=%b pen=%b rdy=%b err=%b required all zero",
               slv_psel, slv_penable, mst_pready, mst_pslverr);
    end
    step();
    psel = 1'b1; paddr = 32'h2000;
    mid();
    n_tests++;
    if (slv_psel !== 4'b0100) begin
      n_fail++;
      $display("FAIL abort_next_setup: psel=%b required 0100", slv_psel);
    end
    step();
    idle_bus();
    step();
  endtask

  task automatic test_timeout();
    step();
    idle_bus();
    psel = 1'b1; paddr = 32'h3000; prdata[3] = 32'h3333_3333;
`ifdef APB_MUX_TIMEOUT_EN
    for (int v = 0; v < 2; v++) begin
      for (int c = 1; c <= 16; c++) begin
        step();
        penable = 1'b1;
        mid();
        n_tests++;
        if ({slv_psel, mst_pready} !== {4'b1000, 1'b0}) begin
          n_fail++;
          $display("FAIL timeout_wait[v%0d c%0d]: psel=%b rdy=%b required 1000/0", v, c, slv_psel, mst_pready);
        end
      end
      step();
      pready[3] = (v == 1);
      mid();
      n_tests++;
      if (v == 0) begin
        if ({slv_psel, slv_penable, mst_pready, mst_pslverr, mst_prdata} !==
            {4'b0000, 1'b0, 1'b1, 1'b1, 32'h0}) begin
          n_fail++;
          $display("FAIL timeout_abort: psel=%b pen=%b rdy=%b err=%b data=%h required 0000/0/1/1/0",
                   slv_psel, slv_penable, mst_pready, mst_pslverr, mst_prdata);
        end
      end else begin
        if ({slv_psel, slv_penable, mst_pready, mst_pslverr, mst_prdata} !==
            {4'b1000, 1'b1, 1'b1, 1'b0, 32'h3333_3333}) begin
          n_fail++;
          $display("FAIL timeout_late_ready: psel=%b pen=%b rdy=%b err=%b data=%h required 1000/1/1/0/33333333",
                   slv_psel, slv_penable, mst_pready, mst_pslverr, mst_prdata);
        end
      end
      step();
      penable = 1'b0; pready[3] = 1'b0;
    end
`else
    for (int c = 1; c <= 20; c++) begin
      step();
      penable = 1'b1;
      mid();
      n_tests++;
      if ({slv_psel, mst_pready, mst_pslverr} !== {4'b1000, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL nowait_limit[c%0d]: psel=%b rdy=%b err=%b required 1000/0/0", c, slv_psel, mst_pready, mst_pslverr);
      end
    end
    step();
    pready[3] = 1'b1;
    mid();
    n_tests++;
    if ({slv_psel, mst_pready, mst_pslverr, mst_prdata} !== {4'b1000, 1'b1, 1'b0, 32'h3333_3333}) begin
      n_fail++;
      $display("FAIL nowait_done: psel=%b rdy=%b err=%b data=%h required 1000/1/0/33333333",
               slv_psel, mst_pready, mst_pslverr, mst_prdata);
    end
    step();
`endif
    idle_bus();
  endtask

  task automatic test_reset_mid_transfer();
    step();
    idle_bus();
    psel = 1'b1; paddr = 32'h1000;
    step();
    penable = 1'b1;
    step();
    step();
    presetn = 1'b0; pready[1] = 1'b1;
    #1;
    n_tests++;
    if ({slv_psel, slv_penable, mst_pready, mst_pslverr, mst_prdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: psel=%b pen=%b rdy=%b err=%b data=%h required all zero",
               slv_psel, slv_penable, mst_pready, mst_pslverr, mst_prdata);
    end
    idle_bus();
    step();
    presetn = 1'b1;
    step();
    psel = 1'b1; paddr = 32'h2008; pready[2] = 1'b1; prdata[2] = 32'h2222_0002;
    mid();
    n_tests++;
    if (slv_psel !== 4'b0100) begin
      n_fail++;
      $display("FAIL reset_after_setup: psel=%b required 0100", slv_psel);
    end
    step();
    penable = 1'b1;
    mid();
    n_tests++;
    if ({slv_psel, mst_pready, mst_pslverr, mst_prdata} !== {4'b0100, 1'b1, 1'b0, 32'h2222_0002}) begin
      n_fail++;
      $display("FAIL reset_after_access: psel=%b rdy=%b err=%b data=%h required 0100/1/0/22220002",
               slv_psel, mst_pready, mst_pslverr, mst_prdata);
    end
    step();
    idle_bus();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_read();
    test_decerr();
    test_wait_states();
    test_back_to_back();
    test_abort();
    test_timeout();
    test_reset_mid_transfer();
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
